// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: issues word fetches, tags them with their PC,
// buffers returned words in order and hands them to the decoder one per handshake.
module instruction_fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int                       BUFFER_DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_request,
  output logic [ADDRESS_WIDTH-1:0] imem_address,
  input  logic                     imem_ready,
  input  logic                     imem_response_valid,
  input  logic [31:0]              imem_read_data,
  output logic [31:0]              instruction,
  output logic [ADDRESS_WIDTH-1:0] instruction_pc,
  output logic                     instruction_valid,
  input  logic                     instruction_ready,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]         PTR_ONE     = PTR_W'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]           DEPTH_LIMIT = (CNT_W+1)'(BUFFER_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP   = ADDRESS_WIDTH'(4);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         discard;

  // Returned words and their PCs, kept in fetch order.
  logic [31:0]              buf_data [BUFFER_DEPTH];
  logic [ADDRESS_WIDTH-1:0] buf_pc   [BUFFER_DEPTH];
  logic [PTR_W-1:0]         buf_head;
  logic [PTR_W-1:0]         buf_tail;
  logic [CNT_W-1:0]         buf_count;

  // Address of every accepted fetch, popped as its response returns.
  logic [ADDRESS_WIDTH-1:0] tag_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]         tag_head;
  logic [PTR_W-1:0]         tag_tail;

  logic                     pop;
  logic                     accept;
  logic                     response;
  logic                     response_drop;
  logic                     response_keep;
  logic [CNT_W:0]           pending;
  logic [CNT_W-1:0]         outstanding_next;
  logic [ADDRESS_WIDTH-1:0] target_aligned;
  logic                     unused_target_bits;

  assign target_aligned     = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];

  assign pop           = (buf_count != '0) && instruction_ready;
  assign response      = imem_response_valid && (outstanding != '0);
  assign response_drop = response && ((discard != '0) || redirect);
  assign response_keep = response && !response_drop;

  // Slots already committed: buffered words (less the one leaving now) plus fetches in flight.
  assign pending = {1'b0, buf_count} + {1'b0, outstanding} - {{CNT_W{1'b0}}, pop};

  // Gated by reset so memory never sees a request the reset is about to abandon.
  assign imem_request = !reset && (state == RUN) && !redirect && (pending < DEPTH_LIMIT);
  assign imem_address = fetch_pc;
  assign accept       = imem_request && imem_ready;

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !response) begin
      outstanding_next = outstanding + CNT_ONE;
    end else if (!accept && response) begin
      outstanding_next = outstanding - CNT_ONE;
    end
  end

  assign instruction_valid = (buf_count != '0);

  always_comb begin
    instruction    = '0;
    instruction_pc = '0;
    if (buf_count != '0) begin
      instruction    = buf_data[buf_head];
      instruction_pc = buf_pc[buf_head];
    end
  end

  // Storage arrays need no reset: occupancy and pointers decide what is live.
  always_ff @(posedge clock) begin
    if (accept) begin
      tag_q[tag_tail] <= fetch_pc;
    end
    if (response_keep) begin
      buf_data[buf_tail] <= imem_read_data;
      buf_pc[buf_tail]   <= tag_q[tag_head];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
      buf_head    <= '0;
      buf_tail    <= '0;
      buf_count   <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (accept) begin
        tag_tail <= tag_tail + PTR_ONE;
        fetch_pc <= fetch_pc + ADDR_STEP;
      end
      if (response) begin
        tag_head <= tag_head + PTR_ONE;
      end
      if (redirect) begin
        // Everything still in flight belongs to the abandoned path.
        fetch_pc  <= target_aligned;
        buf_head  <= '0;
        buf_tail  <= '0;
        buf_count <= '0;
        discard   <= outstanding_next;
        state     <= (outstanding_next != '0) ? FLUSH : RUN;
      end else begin
        if (response_keep) begin
          buf_tail <= buf_tail + PTR_ONE;
        end
        if (pop) begin
          buf_head <= buf_head + PTR_ONE;
        end
        if (response_keep && !pop) begin
          buf_count <= buf_count + CNT_ONE;
        end else if (!response_keep && pop) begin
          buf_count <= buf_count - CNT_ONE;
        end
        if (response_drop) begin
          discard <= discard - CNT_ONE;
        end
        if ((state == FLUSH) && (discard == '0)) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_instruction_fetch_unit;

  localparam int          AW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic          clock;
  logic          reset;
  logic          imem_request;
  logic [AW-1:0] imem_address;
  logic          imem_ready;
  logic          imem_response_valid;
  logic [31:0]   imem_read_data;
  logic [31:0]   instruction;
  logic [AW-1:0] instruction_pc;
  logic          instruction_valid;
  logic          instruction_ready;
  logic          redirect;
  logic [AW-1:0] redirect_target;

  instruction_fetch_unit #(
    .ADDRESS_WIDTH(AW),
    .RESET_VECTOR (RV),
    .BUFFER_DEPTH (DEPTH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .imem_request       (imem_request),
    .imem_address       (imem_address),
    .imem_ready         (imem_ready),
    .imem_response_valid(imem_response_valid),
    .imem_read_data     (imem_read_data),
    .instruction        (instruction),
    .instruction_pc     (instruction_pc),
    .instruction_valid  (instruction_valid),
    .instruction_ready  (instruction_ready),
    .redirect           (redirect),
    .redirect_target    (redirect_target)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- drive controls ----------------
  logic        drv_reset;
  logic        drv_ready;
  logic        drv_iready;
  logic        drv_redirect;
  logic [31:0] drv_target;
  logic        mem_hold;
  logic        force_resp;
  logic [31:0] force_data;
  logic        rand_data;
  int unsigned lat_min;
  int unsigned lat_max;

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } mem_entry_t;

  mem_entry_t  mem_q[$];
  logic [63:0] exp_q[$];       // {pc, word} of buffered instructions, head first
  logic [31:0] m_inflight[$];  // addresses accepted but not yet answered
  logic [31:0] m_fetch_pc;
  int          m_discard;
  bit          m_flushing;
  int unsigned last_due;
  int unsigned cyc;
  bit          armed;

  int n_checks;
  int n_fail;

  function automatic logic [31:0] mem_word(logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step();
    bit          pop;
    bit          resp;
    bit          exp_req;
    bit          fl0;
    int          d0;
    logic [63:0] head;
    logic [31:0] tag;
    mem_entry_t  e;
    @(negedge clock);
    reset             = drv_reset;
    imem_ready        = drv_ready;
    instruction_ready = drv_iready;
    redirect          = drv_redirect;
    redirect_target   = drv_target;
    if (force_resp) begin
      imem_response_valid = 1'b1;
      imem_read_data      = force_data;
      force_resp          = 1'b0;
    end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_response_valid = 1'b1;
      imem_read_data      = mem_q[0].data;
      mem_q.pop_front();
    end else begin
      imem_response_valid = 1'b0;
      imem_read_data      = $urandom;
    end
    #1;
    pop     = (exp_q.size() > 0) && instruction_ready;
    exp_req = !reset && !m_flushing && !redirect &&
              ((exp_q.size() - int'(pop) + m_inflight.size()) < DEPTH);
    head    = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
    if (armed) begin
      check("imem_request", imem_request, exp_req);
      check("imem_address", imem_address, m_fetch_pc);
      check("instruction_valid", instruction_valid, exp_q.size() > 0);
      check("instruction", instruction, head[31:0]);
      check("instruction_pc", instruction_pc, head[63:32]);
    end
    if (reset) begin
      m_fetch_pc = RV;
      exp_q.delete();
      m_inflight.delete();
      mem_q.delete();
      m_discard  = 0;
      m_flushing = 1'b0;
      last_due   = 0;
      armed      = 1'b1;
    end else begin
      fl0  = m_flushing;
      d0   = m_discard;
      resp = imem_response_valid && (m_inflight.size() > 0);
      if (pop) head = exp_q.pop_front();
      if (resp) begin
        tag = m_inflight.pop_front();
        if (redirect || m_discard > 0) begin
          if (m_discard > 0) m_discard--;
        end else begin
          exp_q.push_back({tag, imem_read_data});
        end
      end
      if (exp_req && imem_ready) begin
        e.due  = cyc + $urandom_range(lat_min, lat_max);
        if (e.due <= last_due) e.due = last_due + 1;
        last_due = e.due;
        e.data = mem_word(m_fetch_pc) ^ (rand_data ? $urandom : 32'h0);
        mem_q.push_back(e);
        m_inflight.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        m_fetch_pc = {drv_target[31:2], 2'b00};
        m_discard  = m_inflight.size();
        m_flushing = (m_discard > 0);
      end else if (fl0 && d0 == 0) begin
        m_flushing = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    drv_ready    = 1'b0;
    drv_iready   = 1'b1;
    drv_redirect = 1'b0;
    mem_hold     = 1'b0;
    for (int i = 0; i < 50 && (m_inflight.size() > 0 || exp_q.size() > 0); i++) step();
    step();
    check("drain_valid", instruction_valid, 1'b0);
  endtask

  task automatic redirect_to(logic [31:0] t);
    drv_redirect = 1'b1;
    drv_target   = t;
    step();
    drv_redirect = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; armed = 1'b0;
    m_fetch_pc = RV; m_discard = 0; m_flushing = 1'b0; last_due = 0;
    drv_reset = 1'b1; drv_ready = 1'b0; drv_iready = 1'b0; drv_redirect = 1'b0;
    drv_target = 32'h0; mem_hold = 1'b0; force_resp = 1'b0; force_data = 32'h0;
    rand_data = 1'b0; lat_min = 1; lat_max = 1;
    reset = 1'b1; imem_ready = 1'b0; imem_response_valid = 1'b0; imem_read_data = 32'h0;
    instruction_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

    // Reset values
    step(); step();
    check("rst_request", imem_request, 1'b0);
    check("rst_address", imem_address, 32'h0);
    check("rst_valid", instruction_valid, 1'b0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_pc", instruction_pc, 32'h0);

    // Streaming with 1-cycle latency
    drv_reset = 1'b0; drv_ready = 1'b1; drv_iready = 1'b1;
    step();
    check("t1_addr0", imem_address, 32'h0);
    check("t1_req0", imem_request, 1'b1);
    check("t1_valid0", instruction_valid, 1'b0);
    step();
    check("t1_addr1", imem_address, 32'h4);
    check("t1_valid1", instruction_valid, 1'b0);
    step();
    check("t1_valid2", instruction_valid, 1'b1);
    check("t1_pc0", instruction_pc, 32'h0);
    check("t1_data0", instruction, 32'h0000_FFFF);
    check("t1_addr2", imem_address, 32'h8);
    step();
    check("t1_pc1", instruction_pc, 32'h4);
    check("t1_data1", instruction, 32'h0004_FFFB);
    step();
    check("t1_pc2", instruction_pc, 32'h8);
    check("t1_data2", instruction, 32'h0008_FFF7);

    // Decoder stalled: buffer fills, requests stop, resume at 0x8
    drv_reset = 1'b1; step(); drv_reset = 1'b0;
    drv_ready = 1'b1; drv_iready = 1'b0;
    repeat (5) step();
    check("t2_req_stalled", imem_request, 1'b0);
    check("t2_valid", instruction_valid, 1'b1);
    check("t2_pc_head", instruction_pc, 32'h0);
    check("t2_data_head", instruction, 32'h0000_FFFF);
    drv_iready = 1'b1;
    step();
    check("t2_resume_req", imem_request, 1'b1);
    check("t2_resume_addr", imem_address, 32'h8);

    // Redirect with two fetches in flight
    drain();
    redirect_to(32'h10);
    mem_hold = 1'b1; drv_ready = 1'b1; drv_iready = 1'b1;
    step();
    check("t3_addr10", imem_address, 32'h10);
    step();
    check("t3_addr14", imem_address, 32'h14);
    redirect_to(32'h103);
    step();
    check("t3_flush_req_a", imem_request, 1'b0);
    step();
    check("t3_flush_req_b", imem_request, 1'b0);
    mem_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_request) break;
    end
    check("t3_req_after_flush", imem_request, 1'b1);
    check("t3_addr100", imem_address, 32'h100);
    for (int i = 0; i < 10; i++) begin
      step();
      if (instruction_valid) break;
    end
    check("t3_first_valid", instruction_valid, 1'b1);
    check("t3_first_pc", instruction_pc, 32'h100);
    check("t3_first_data", instruction, 32'h0100_FEFF);

    // Redirect together with a response and a consume
    drain();
    redirect_to(32'h30);
    drv_ready = 1'b1; drv_iready = 1'b1;
    repeat (4) step();
    redirect_to(32'h200);
    step();
    check("t4_valid", instruction_valid, 1'b0);
    check("t4_instruction", instruction, 32'h0);
    check("t4_addr", imem_address, 32'h200);
    check("t4_req", imem_request, 1'b1);

    // Memory not ready: address held; then wrap at the top of the address space
    drain();
    redirect_to(32'h20);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_addr_hold", imem_address, 32'h20);
      check("t5_req_hold", imem_request, 1'b1);
    end
    redirect_to(32'hFFFF_FFFC);
    drv_ready = 1'b1;
    step();
    check("t5_addr_top", imem_address, 32'hFFFF_FFFC);
    step();
    check("t5_addr_wrap", imem_address, 32'h0);

    // Reset while flushing with one fetch outstanding
    drain();
    redirect_to(32'h40);
    drv_ready = 1'b1; mem_hold = 1'b1;
    step();
    check("t6_addr40", imem_address, 32'h40);
    drv_ready = 1'b0;
    redirect_to(32'h80);
    step();
    check("t6_flush_req", imem_request, 1'b0);
    drv_reset = 1'b1;
    step(); step();
    check("t6_rst_req", imem_request, 1'b0);
    check("t6_rst_addr", imem_address, 32'h0);
    check("t6_rst_valid", instruction_valid, 1'b0);
    check("t6_rst_pc", instruction_pc, 32'h0);
    drv_reset = 1'b0; mem_hold = 1'b0; drv_ready = 1'b1; drv_iready = 1'b1;
    force_resp = 1'b1; force_data = 32'hDEAD_BEEF;
    step();
    check("t6_restart_addr", imem_address, 32'h0);
    check("t6_restart_req", imem_request, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (instruction_valid) break;
    end
    check("t6_first_pc", instruction_pc, 32'h0);
    check("t6_first_data", instruction, 32'h0000_FFFF);

    // Randomized traffic
    rand_data = 1'b1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      drv_ready    = ($urandom_range(0, 9) < 7);
      drv_iready   = ($urandom_range(0, 9) < 6);
      drv_redirect = ($urandom_range(0, 99) < 4);
      drv_target   = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drv_reset    = ($urandom_range(0, 999) < 3);
      mem_hold     = ($urandom_range(0, 9) == 0);
      if (mem_q.size() == 0 && $urandom_range(0, 49) == 0) begin
        force_resp = 1'b1;
        force_data = $urandom;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the Armv4 core. Generates instruction-memory requests, buffers the returned words, and presents one instruction per handshake to the controller/decoder.
- Takes the controller's resolved branch (pc_source plus target) as a redirect. On redirect it flushes buffered and in-flight fetches.
- Decouples variable-latency instruction memory from the core with an in-order prefetch buffer.

Parameters:
ADDRESS_WIDTH, 32, width of PC and memory address
RESET_VECTOR, 32'h0000_0000, first fetch address after reset (word aligned)
BUFFER_DEPTH, 2, prefetch buffer entries; also the cap on outstanding plus buffered fetches (power of two, 2..8)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
imem_request  output  1  request valid toward instruction memory
imem_address  output  ADDRESS_WIDTH  word-aligned fetch address, valid with imem_request
imem_ready  input  1  memory accepts request this cycle
imem_response_valid  input  1  read data returning, strictly in request order
imem_read_data  input  32  returned instruction word
instruction  output  32  head-of-buffer instruction to decoder
instruction_pc  output  ADDRESS_WIDTH  address of the head instruction
instruction_valid  output  1  head entry present
instruction_ready  input  1  controller consumes head this cycle
redirect  input  1  branch taken (controller pc_source)
redirect_target  input  ADDRESS_WIDTH  new fetch address; bits [1:0] ignored, forced to 0

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc = RESET_VECTOR; buffer empty; outstanding = 0; discard = 0; state RUN.
  - Outputs: imem_request = 0, imem_address = RESET_VECTOR, instruction = 0, instruction_pc = 0, instruction_valid = 0.
  - Reset mid-operation abandons all in-flight fetches. A response arriving in the cycle reset is asserted is dropped.
- Request issue:
  - In RUN, imem_request = 1 when (buffer occupancy - pop_this_cycle + outstanding) < BUFFER_DEPTH and redirect = 0. This is combinational from registered state and the two inputs.
  - imem_address = fetch_pc.
  - Accept occurs on imem_request && imem_ready. On accept: fetch_pc += 4 (wraps modulo 2^ADDRESS_WIDTH), outstanding += 1, and the address is pushed into an internal pc-tag queue of depth BUFFER_DEPTH.
  - With imem_request high and imem_ready low, address stays stable.
- Response:
  - imem_response_valid with discard > 0: word dropped, discard -= 1, outstanding -= 1, tag popped.
  - Otherwise the word and its tag are written to the buffer tail and outstanding -= 1.
  - Response with outstanding = 0 is a protocol error and is ignored.
- Latency: request accepted at cycle t, response at t+k (k >= 1), instruction_valid high from cycle t+k+1. The buffer is registered; there is no bypass.
- Consume:
  - instruction/instruction_pc always reflect the buffer head.
  - Pop on instruction_valid && instruction_ready. Push and pop in the same cycle are allowed, including when the buffer is full.
  - When empty, instruction = 0 and instruction_pc = 0.
- Redirect (highest priority):
  - Buffer cleared and fetch_pc = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00}.
  - discard = outstanding after this cycle's response accounting. A response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
  - State goes to FLUSH if that discard > 0, otherwise RUN.
  - A same-cycle consume still counts as taken (the decoder already has it), but the buffer is cleared regardless.
- FSM:
  - RUN: normal issue.
  - FLUSH: no requests; go to RUN in the cycle after discard reaches 0.
  - Redirect in FLUSH reloads fetch_pc and recomputes discard; it does not double-count.
- Invariants: occupancy + outstanding <= BUFFER_DEPTH; discard <= outstanding; responses never reordered.

Test Plan:
- Reset, then imem_ready = 1, 1-cycle response latency, instruction_ready = 1 -> addresses 0x0, 0x4, 0x8; instruction_valid first high 2 cycles after first accept; instruction_pc follows 0x0, 0x4, 0x8 with matching data.
- instruction_ready = 0, BUFFER_DEPTH = 2 -> after 2 accepts imem_request drops; buffer holds 0x0/0x4 words; releasing ready resumes requests at 0x8.
- Two requests in flight (0x10, 0x14), redirect to 0x103 -> both responses dropped, no request until they return, then request at 0x100; first valid instruction_pc = 0x100.
- Redirect in the same cycle as a response and a consume -> response dropped, buffer empty next cycle, instruction_valid = 0, fetch_pc = target.
- imem_ready held low 5 cycles -> imem_address stable at 0x20, outstanding unchanged. fetch_pc = 0xFFFF_FFFC accepted -> next address 0x0.
- Reset asserted in FLUSH with 1 outstanding -> all outputs return to reset values next cycle; a late response is ignored; fetch restarts at RESET_VECTOR.
